// File: rtl/ps_pkg.sv
// Shared PacketStream definitions: default widths used by stream interfaces and blocks.
package ps_pkg;

    localparam int PS_WIDTH    = 8;
    localparam int PS_LENWIDTH = 16;
    localparam int PS_CNTWIDTH = 32;

endpackage

// File: rtl/ps_packet_framer_if.sv
// PacketStream interfaces: raw source stream (eop only) and framed stream (sop + eop).
interface ps_src_if import ps_pkg::*; #(parameter int WIDTH = PS_WIDTH);

    logic [WIDTH-1:0] dat;
    logic             val;
    logic             eop;
    logic             rdy;

    modport master (output dat, output val, output eop, input rdy);
    modport slave  (input dat, input val, input eop, output rdy);

endinterface

interface ps_pkt_if import ps_pkg::*; #(parameter int WIDTH = PS_WIDTH);

    logic [WIDTH-1:0] dat;
    logic             val;
    logic             sop;
    logic             eop;
    logic             rdy;

    modport master (output dat, output val, output sop, output eop, input rdy);
    modport slave  (input dat, input val, input sop, input eop, output rdy);

endinterface

// File: rtl/ps_out_reg.sv
// One-stage val/rdy register slice for framed PacketStream words (dat/sop/eop).
module ps_out_reg import ps_pkg::*; #(
    parameter int WIDTH = PS_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             in_val,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_rdy,
    ps_pkt_if.master         pkt_out
);

    logic [WIDTH-1:0] dat_r;
    logic             val_r;
    logic             sop_r;
    logic             eop_r;
    logic             load_s;

    // The slot may be refilled whenever it is empty or being drained this cycle.
    assign in_rdy = ~val_r | pkt_out.rdy;
    assign load_s = in_val & in_rdy;

    // Output slot: load on accept, empty on drain, otherwise hold the word stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dat_r <= {WIDTH{1'b0}};
            val_r <= 1'b0;
            sop_r <= 1'b0;
            eop_r <= 1'b0;
        end else if (load_s) begin
            dat_r <= in_dat;
            val_r <= 1'b1;
            sop_r <= in_sop;
            eop_r <= in_eop;
        end else if (pkt_out.rdy) begin
            val_r <= 1'b0;
        end
    end

    assign pkt_out.dat = dat_r;
    assign pkt_out.val = val_r;
    assign pkt_out.sop = sop_r;
    assign pkt_out.eop = eop_r;

endmodule

// File: rtl/ps_packet_framer.sv
// Adds sop to an eop-only PacketStream and optionally cuts packets into segments of
// at most ctl_len words by forcing eop; output goes through a one-stage register slice.
module ps_packet_framer import ps_pkg::*; #(
    parameter int WIDTH    = PS_WIDTH,
    parameter int LENWIDTH = PS_LENWIDTH,
    parameter int CNTWIDTH = PS_CNTWIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    ps_src_if.slave             src,
    ps_pkt_if.master            dst,
    input  logic [LENWIDTH-1:0] ctl_len,
    output logic [CNTWIDTH-1:0] stat_pkt_cnt,
    output logic                stat_cut
);

    logic                sop_r;
    logic [LENWIDTH-1:0] cnt_r;
    logic [LENWIDTH-1:0] len_r;
    logic [CNTWIDTH-1:0] pkt_cnt_r;
    logic                stat_cut_r;

    logic [LENWIDTH-1:0] len_e_s;
    logic                cut_s;
    logic                eop_s;
    logic                accept_s;
    logic                rdy_s;

    // Segment length is sampled at sop so mid-packet ctl_len changes wait for the next segment.
    always_comb begin
        len_e_s  = sop_r ? ctl_len : len_r;
        cut_s    = (len_e_s != {LENWIDTH{1'b0}}) && (cnt_r == (len_e_s - LENWIDTH'(1)));
        eop_s    = src.eop | cut_s;
        accept_s = src.val & rdy_s;
    end

    assign src.rdy = rdy_s;

    // Framing state: next-word-is-sop flag, word position in segment, latched length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sop_r <= 1'b1;
            cnt_r <= {LENWIDTH{1'b0}};
            len_r <= {LENWIDTH{1'b0}};
        end else if (accept_s) begin
            if (sop_r) begin
                len_r <= ctl_len;
            end
            sop_r <= eop_s;
            cnt_r <= eop_s ? {LENWIDTH{1'b0}} : (cnt_r + LENWIDTH'(1));
        end
    end

    // Statistics: packets entering the output stage and forced-eop pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_r  <= {CNTWIDTH{1'b0}};
            stat_cut_r <= 1'b0;
        end else begin
            stat_cut_r <= accept_s & cut_s & ~src.eop;
            if (accept_s & eop_s) begin
                pkt_cnt_r <= pkt_cnt_r + CNTWIDTH'(1);
            end
        end
    end

    assign stat_pkt_cnt = pkt_cnt_r;
    assign stat_cut     = stat_cut_r;

    ps_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .in_dat  (src.dat),
        .in_val  (src.val),
        .in_sop  (sop_r),
        .in_eop  (eop_s),
        .in_rdy  (rdy_s),
        .pkt_out (dst)
    );

endmodule

// File: tb/tb_ps_packet_framer.sv
// Directed and randomised-backpressure checks of ps_packet_framer framing and handshake.
module tb_ps_packet_framer;

    logic        clk;
    logic        reset_n;
    logic [15:0] ctl_len;
    logic [31:0] stat_pkt_cnt;
    logic        stat_cut;

    int vec  = 0;
    int miss = 0;

    ps_src_if #(.WIDTH(8)) src_if ();
    ps_pkt_if #(.WIDTH(8)) dst_if ();

    ps_packet_framer #(
        .WIDTH    (8),
        .LENWIDTH (16),
        .CNTWIDTH (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .src          (src_if),
        .dst          (dst_if),
        .ctl_len      (ctl_len),
        .stat_pkt_cnt (stat_pkt_cnt),
        .stat_cut     (stat_cut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input word for one clock; returns 1 time unit after the edge.
    task automatic drive(input logic [7:0] d, input logic v, input logic e);
        src_if.dat = d;
        src_if.val = v;
        src_if.eop = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        ctl_len    = 16'd0;
        dst_if.rdy = 1'b1;
        src_if.val = 1'b0;
        src_if.eop = 1'b0;
        src_if.dat = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({dst_if.val, dst_if.sop, dst_if.eop, dst_if.dat} !== 11'd0) begin
            miss++;
            $display("FAIL reset_out: got val/sop/eop/dat=%b/%b/%b/%h want 0/0/0/00",
                     dst_if.val, dst_if.sop, dst_if.eop, dst_if.dat);
        end
        vec++;
        if (stat_pkt_cnt !== 32'd0 || stat_cut !== 1'b0) begin
            miss++;
            $display("FAIL reset_stats: got cnt=%0d cut=%b want 0/0", stat_pkt_cnt, stat_cut);
        end
        vec++;
        if (src_if.rdy !== 1'b1) begin
            miss++;
            $display("FAIL reset_rdy: got %b want 1", src_if.rdy);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [15:0] m_sop = 16'h0001;
        logic [15:0] m_eop = 16'h0004;
        logic [7:0]  d;
        logic [11:0] got, exp;
        ctl_len = 16'd0;
        for (int i = 0; i < 3; i++) begin
            d = 8'(8'h11 * (i + 1));
            drive(d, 1'b1, i == 2);
            got = {dst_if.val, dst_if.dat, dst_if.sop, dst_if.eop, stat_cut};
            exp = {1'b1, d, m_sop[i], m_eop[i], 1'b0};
            vec++;
            if (got !== exp) begin
                miss++;
                $display("FAIL basic_w%0d: got %h want %h", i + 1, got, exp);
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        vec++;
        if (dst_if.val !== 1'b0 || stat_pkt_cnt !== 32'd1) begin
            miss++;
            $display("FAIL basic_end: got val=%b cnt=%0d want 0/1", dst_if.val, stat_pkt_cnt);
        end
    endtask

    task automatic test_segment();
        logic [15:0] m_sop = 16'h0111;
        logic [15:0] m_eop = 16'h0288;
        logic [15:0] m_cut = 16'h0088;
        logic [7:0]  d;
        logic [11:0] got, exp;
        int cuts = 0;
        ctl_len = 16'd4;
        for (int i = 0; i < 10; i++) begin
            d = 8'hA0 + 8'(i);
            drive(d, 1'b1, i == 9);
            got = {dst_if.val, dst_if.dat, dst_if.sop, dst_if.eop, stat_cut};
            exp = {1'b1, d, m_sop[i], m_eop[i], m_cut[i]};
            vec++;
            if (got !== exp) begin
                miss++;
                $display("FAIL seg4_w%0d: got %h want %h", i + 1, got, exp);
            end
            if (stat_cut) cuts++;
        end
        drive(8'h00, 1'b0, 1'b0);
        vec++;
        if (stat_pkt_cnt !== 32'd4 || cuts != 2) begin
            miss++;
            $display("FAIL seg4_stats: got cnt=%0d cuts=%0d want 4/2", stat_pkt_cnt, cuts);
        end
    endtask

    task automatic test_exact_len();
        logic [15:0] m_sop;
        logic [15:0] m_eop;
        logic [15:0] m_cut;
        logic [7:0]  d;
        logic [11:0] got, exp;
        ctl_len = 16'd4;
        m_sop = 16'h0001; m_eop = 16'h0008; m_cut = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d = 8'h40 + 8'(i);
            drive(d, 1'b1, i == 3);
            got = {dst_if.val, dst_if.dat, dst_if.sop, dst_if.eop, stat_cut};
            exp = {1'b1, d, m_sop[i], m_eop[i], m_cut[i]};
            vec++;
            if (got !== exp) begin
                miss++;
                $display("FAIL exact4_w%0d: got %h want %h", i + 1, got, exp);
            end
        end
        ctl_len = 16'd1;
        m_sop = 16'h0007; m_eop = 16'h0007; m_cut = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            d = 8'h50 + 8'(i);
            drive(d, 1'b1, i == 2);
            got = {dst_if.val, dst_if.dat, dst_if.sop, dst_if.eop, stat_cut};
            exp = {1'b1, d, m_sop[i], m_eop[i], m_cut[i]};
            vec++;
            if (got !== exp) begin
                miss++;
                $display("FAIL len1_w%0d: got %h want %h", i + 1, got, exp);
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        vec++;
        if (stat_pkt_cnt !== 32'd8 || stat_cut !== 1'b0) begin
            miss++;
            $display("FAIL exact_stats: got cnt=%0d cut=%b want 8/0", stat_pkt_cnt, stat_cut);
        end
    endtask

    task automatic test_len_change();
        logic [15:0] m_sop = 16'h0051;
        logic [15:0] m_eop = 16'h00A8;
        logic [15:0] m_cut = 16'h0028;
        logic [7:0]  d;
        logic [11:0] got, exp;
        ctl_len = 16'd4;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) ctl_len = 16'd2;
            d = 8'hC0 + 8'(i);
            drive(d, 1'b1, i == 7);
            got = {dst_if.val, dst_if.dat, dst_if.sop, dst_if.eop, stat_cut};
            exp = {1'b1, d, m_sop[i], m_eop[i], m_cut[i]};
            vec++;
            if (got !== exp) begin
                miss++;
                $display("FAIL lenchg_w%0d: got %h want %h", i + 1, got, exp);
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        vec++;
        if (stat_pkt_cnt !== 32'd11) begin
            miss++;
            $display("FAIL lenchg_cnt: got %0d want 11", stat_pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] q[$];
        logic [9:0] held;
        logic [9:0] e;
        bit         done = 1'b0;
        bit         was_stall = 1'b0;
        int         eops = 0;
        ctl_len = 16'd3;
        fork
            begin
                logic [7:0] d;
                logic       sop_e, eop_e, acc;
                int         n, guard;
                for (int p = 0; p < 1000; p++) begin
                    n = $urandom_range(1, 8);
                    for (int w = 0; w < n; w++) begin
                        while ($urandom_range(0, 1) == 0) begin
                            src_if.val = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        d     = 8'($urandom);
                        sop_e = (w % 3) == 0;
                        eop_e = (w == n - 1) || ((w % 3) == 2);
                        eops += int'(eop_e);
                        q.push_back({d, sop_e, eop_e});
                        src_if.dat = d;
                        src_if.eop = (w == n - 1);
                        src_if.val = 1'b1;
                        guard = 0;
                        do begin
                            @(negedge clk);
                            acc = src_if.rdy;
                            @(posedge clk);
                            #1;
                            guard++;
                        end while (!acc && guard < 1000);
                        if (!acc) begin
                            vec++;
                            miss++;
                            $display("FAIL b2b_accept_timeout: pkt %0d word %0d never accepted", p, w);
                        end
                    end
                end
                src_if.val = 1'b0;
                done = 1'b1;
            end
            begin
                int cyc = 0;
                while (!(done && q.size() == 0)) begin
                    @(posedge clk);
                    #1;
                    dst_if.rdy = done ? 1'b1 : 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (was_stall) begin
                        vec++;
                        if (dst_if.val !== 1'b1 || {dst_if.dat, dst_if.sop, dst_if.eop} !== held) begin
                            miss++;
                            $display("FAIL b2b_hold: got val=%b word=%h want 1/%h",
                                     dst_if.val, {dst_if.dat, dst_if.sop, dst_if.eop}, held);
                        end
                    end
                    vec++;
                    if (dst_if.val && !dst_if.rdy) begin
                        if (src_if.rdy !== 1'b0) begin
                            miss++;
                            $display("FAIL b2b_irdy: got %b want 0", src_if.rdy);
                        end
                    end else if (src_if.rdy !== 1'b1) begin
                        miss++;
                        $display("FAIL b2b_irdy: got %b want 1", src_if.rdy);
                    end
                    if (dst_if.val && dst_if.rdy) begin
                        vec++;
                        if (q.size() == 0) begin
                            miss++;
                            $display("FAIL b2b_extra: got word %h want none",
                                     {dst_if.dat, dst_if.sop, dst_if.eop});
                        end else begin
                            e = q.pop_front();
                            if ({dst_if.dat, dst_if.sop, dst_if.eop} !== e) begin
                                miss++;
                                $display("FAIL b2b_word: got %h want %h",
                                         {dst_if.dat, dst_if.sop, dst_if.eop}, e);
                            end
                        end
                    end
                    was_stall = dst_if.val && !dst_if.rdy;
                    held      = {dst_if.dat, dst_if.sop, dst_if.eop};
                    cyc++;
                    if (cyc > 80000) begin
                        vec++;
                        miss++;
                        $display("FAIL b2b_drain_timeout: got %0d words left want 0", q.size());
                        break;
                    end
                end
            end
        join
        dst_if.rdy = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        vec++;
        if (stat_pkt_cnt !== 32'(11 + eops)) begin
            miss++;
            $display("FAIL b2b_cnt: got %0d want %0d", stat_pkt_cnt, 11 + eops);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] m_sop = 16'h0005;
        logic [15:0] m_eop = 16'h0006;
        logic [15:0] m_cut = 16'h0002;
        logic [7:0]  d;
        logic [11:0] got, exp;
        ctl_len = 16'd0;
        drive(8'h71, 1'b1, 1'b0);
        drive(8'h72, 1'b1, 1'b0);
        src_if.val = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        vec++;
        if (dst_if.val !== 1'b0 || stat_pkt_cnt !== 32'd0) begin
            miss++;
            $display("FAIL arst_now: got val=%b cnt=%0d want 0/0", dst_if.val, stat_pkt_cnt);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ctl_len = 16'd2;
        for (int i = 0; i < 3; i++) begin
            d = 8'h90 + 8'(i);
            drive(d, 1'b1, i == 2);
            got = {dst_if.val, dst_if.dat, dst_if.sop, dst_if.eop, stat_cut};
            exp = {1'b1, d, m_sop[i], m_eop[i], m_cut[i]};
            vec++;
            if (got !== exp) begin
                miss++;
                $display("FAIL arst_w%0d: got %h want %h", i + 1, got, exp);
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        vec++;
        if (stat_pkt_cnt !== 32'd2) begin
            miss++;
            $display("FAIL arst_cnt: got %0d want 2", stat_pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_segment();
        test_exact_len();
        test_len_change();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
